// File: rtl/cla_adder_32bit_pipe_pkg.sv
// Shared constants, lookahead types and the group P/G combine used by the CLA adder/subtractor family.
// Also holds the stage-1 register layout; sign bits are present only with CLA_ADD_OVF_EN.
package cla_adder_32bit_pipe_pkg;

    localparam int WIDTH = 32;
    localparam int GRP_W = 16;
    localparam int BLK_W = 4;
    localparam int NBLK  = GRP_W / BLK_W;

    typedef struct packed {
        logic p;
        logic g;
    } pg_t;

    // Merge a more-significant span (hi) onto a less-significant span (lo).
    function automatic pg_t pg_combine(input pg_t hi, input pg_t lo);
        pg_t r;
        r.p = hi.p & lo.p;
        r.g = hi.g | (hi.p & lo.g);
        return r;
    endfunction

    typedef struct packed {
        logic [GRP_W-1:0] x_hi;
        logic [GRP_W-1:0] y_hi;
        logic [GRP_W-1:0] s_lo;
        logic             p_lo;
        logic             g_lo;
        logic             c16;
`ifdef CLA_ADD_OVF_EN
        logic             x_msb;
        logic             y_msb;
`endif
    } s1_t;

endpackage

// File: rtl/cla_add_16bit.sv
// Combinational 16-bit carry-lookahead adder: four 4-bit lookahead blocks under one group lookahead.
// Zero latency, no handshake; exports group propagate/generate for the caller's next lookahead level.
module cla_add_16bit
    import cla_adder_32bit_pipe_pkg::*;
(
    input  logic [GRP_W-1:0] x,
    input  logic [GRP_W-1:0] y,
    input  logic             cin,
    output logic [GRP_W-1:0] sum,
    output logic             pg,
    output logic             gg
);

    logic [GRP_W-1:0] p;
    logic [GRP_W-1:0] g;
    pg_t  [NBLK-1:0]  blk;
    logic [NBLK-1:0]  bc;
    pg_t              grp;
    logic             cc;

    always_comb begin
        p = x ^ y;
        g = x & y;
        for (int b = 0; b < NBLK; b++) begin
            blk[b].p = &p[BLK_W*b +: BLK_W];
            blk[b].g = g[BLK_W*b+3]
                     | (p[BLK_W*b+3] & g[BLK_W*b+2])
                     | (p[BLK_W*b+3] & p[BLK_W*b+2] & g[BLK_W*b+1])
                     | ((&p[BLK_W*b+1 +: 3]) & g[BLK_W*b]);
        end
    end

    // Block carry-ins are resolved in parallel from cin, not rippled block to block.
    always_comb begin
        bc[0] = cin;
        bc[1] = blk[0].g | (blk[0].p & cin);
        bc[2] = blk[1].g | (blk[1].p & blk[0].g) | (blk[1].p & blk[0].p & cin);
        bc[3] = blk[2].g | (blk[2].p & blk[1].g) | (blk[2].p & blk[1].p & blk[0].g)
              | (blk[2].p & blk[1].p & blk[0].p & cin);

        sum = '0;
        cc  = 1'b0;
        for (int b = 0; b < NBLK; b++) begin
            cc = bc[b];
            for (int i = 0; i < BLK_W; i++) begin
                sum[BLK_W*b+i] = p[BLK_W*b+i] ^ cc;
                cc = g[BLK_W*b+i] | (p[BLK_W*b+i] & cc);
            end
        end
    end

    always_comb begin
        grp = pg_combine(pg_combine(blk[3], blk[2]), pg_combine(blk[1], blk[0]));
        pg  = grp.p;
        gg  = grp.g;
    end

endmodule

// File: rtl/cla_adder_32bit_pipe.sv
// Two-stage pipelined 32-bit CLA adder: low half in stage 1, high half in stage 2; 2-cycle latency.
// Valid/ready with 2-entry capacity and bubble collapse; CLA_ADD_OVF_EN adds the signed-overflow port.
module cla_adder_32bit_pipe
    import cla_adder_32bit_pipe_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             GP,
    output logic             GG
`ifdef CLA_ADD_OVF_EN
    ,
    output logic             ovf
`endif
);

    logic             s1_valid;
    s1_t              s1_q;
    s1_t              s1_d;
    logic             s2_adv;
    logic             s1_adv;
    logic             accept;

    logic [GRP_W-1:0] s_lo_c;
    logic             lo_p;
    logic             lo_g;
    logic [GRP_W-1:0] s_hi_c;
    logic             hi_p;
    logic             hi_g;
    pg_t              word_pg;
    logic             cout_d;

    // Output register frees up when empty or draining; s1 only moves into a free output register.
    always_comb begin
        s2_adv   = !out_valid || out_ready;
        s1_adv   = s1_valid && s2_adv;
        in_ready = !s1_valid || s1_adv;
        accept   = in_valid && in_ready;
    end

    cla_add_16bit u_add_lo (
        .x   (x[GRP_W-1:0]),
        .y   (y[GRP_W-1:0]),
        .cin (cin),
        .sum (s_lo_c),
        .pg  (lo_p),
        .gg  (lo_g)
    );

    always_comb begin
        s1_d      = '0;
        s1_d.x_hi = x[WIDTH-1:GRP_W];
        s1_d.y_hi = y[WIDTH-1:GRP_W];
        s1_d.s_lo = s_lo_c;
        s1_d.p_lo = lo_p;
        s1_d.g_lo = lo_g;
        s1_d.c16  = lo_g | (lo_p & cin);
`ifdef CLA_ADD_OVF_EN
        s1_d.x_msb = x[WIDTH-1];
        s1_d.y_msb = y[WIDTH-1];
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_q     <= '0;
        end else if (accept) begin
            s1_valid <= 1'b1;
            s1_q     <= s1_d;
        end else if (s1_adv) begin
            s1_valid <= 1'b0;
        end
    end

    cla_add_16bit u_add_hi (
        .x   (s1_q.x_hi),
        .y   (s1_q.y_hi),
        .cin (s1_q.c16),
        .sum (s_hi_c),
        .pg  (hi_p),
        .gg  (hi_g)
    );

    always_comb begin
        word_pg = pg_combine('{p: hi_p, g: hi_g}, '{p: s1_q.p_lo, g: s1_q.g_lo});
        cout_d  = hi_g | (hi_p & s1_q.c16);
    end

    // Data registers load only with a real result so a collapsing bubble never disturbs them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            s         <= '0;
            cout      <= 1'b0;
            GP        <= 1'b0;
            GG        <= 1'b0;
`ifdef CLA_ADD_OVF_EN
            ovf       <= 1'b0;
`endif
        end else if (s2_adv) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                s    <= {s_hi_c, s1_q.s_lo};
                cout <= cout_d;
                GP   <= word_pg.p;
                GG   <= word_pg.g;
`ifdef CLA_ADD_OVF_EN
                ovf  <= (s1_q.x_msb == s1_q.y_msb) & (s_hi_c[GRP_W-1] != s1_q.x_msb);
`endif
            end
        end
    end

endmodule
